// File: rtl/dmem_pkg.sv
// dmem_pkg: access sizes, FSM states and wait-state limit shared by data_memory_bus.
package dmem_pkg;

    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD} size_t;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam int WAIT_MAX = 15;

endpackage

// File: rtl/dmem_lane_unit.sv
// dmem_lane_unit: byte-lane steering for stores and lane extraction/extension for loads.
module dmem_lane_unit
    import dmem_pkg::*;
(
    input  size_t       size,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    input  logic        uns,
    output logic [3:0]  be,
    output logic [31:0] wword,
    output logic [31:0] ldata,
    output logic        misalign
);

    logic [1:0]  lane;
    logic [31:0] sh;

    // Low address bits below the access size are dropped; misalign reports whether they were set.
    always_comb begin
        lane     = size == SZ_BYTE ? addr : size == SZ_HALF ? {addr[1], 1'b0} : 2'b00;
        misalign = (size == SZ_HALF && addr[0]) || (size == SZ_WORD && addr != 2'b00);
        be       = size == SZ_BYTE ? 4'b0001 << lane :
                   size == SZ_HALF ? (lane[1] ? 4'b1100 : 4'b0011) :
                   size == SZ_WORD ? 4'b1111 : 4'b0000;
        wword    = wdata << {lane, 3'b000};
        sh       = rdata >> {lane, 3'b000};
        ldata    = size == SZ_BYTE ? {{24{~uns & sh[7]}}, sh[7:0]} :
                   size == SZ_HALF ? {{16{~uns & sh[15]}}, sh[15:0]} :
                   size == SZ_WORD ? rdata : 32'd0;
    end

endmodule

// File: rtl/data_memory_bus.sv
// data_memory_bus: handshaked byte/half/word data memory with WAIT_CYCLES wait states.
// Define DMEM_ALIGN_CHECK_EN to flag misaligned half/word accesses instead of truncating the address.
module data_memory_bus
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int         DEPTH    = 2 ** (ADDR_W - 2);
    localparam int         WAITS    = WAIT_CYCLES > WAIT_MAX ? WAIT_MAX : WAIT_CYCLES;
    localparam logic [3:0] CNT_INIT = WAITS > 0 ? 4'(WAITS - 1) : 4'd0;
`ifdef DMEM_ALIGN_CHECK_EN
    localparam logic ALIGN_EN = 1'b1;
`else
    localparam logic ALIGN_EN = 1'b0;
`endif

    state_t              state, state_d;
    logic [3:0]          cnt;
    logic                q_write, q_unsigned;
    size_t               q_size;
    logic [ADDR_W-1:0]   q_addr;
    logic [31:0]         q_wdata;
    logic                c_write, c_unsigned;
    size_t               c_size;
    logic [ADDR_W-1:0]   c_addr;
    logic [31:0]         c_wdata;
    logic                accept, commit, err, misalign;
    logic [3:0]          be;
    logic [31:0]         wword, ldata, rword;
    logic [31:0]         mem [DEPTH];

    assign req_ready = state == IDLE;
    assign rsp_valid = state == RESP;

    // With no wait states the commit happens on the accept edge, so the live request is used directly.
    always_comb begin
        accept     = req_valid && state == IDLE;
        c_write    = accept ? req_write : q_write;
        c_unsigned = accept ? req_unsigned : q_unsigned;
        c_size     = accept ? size_t'(req_size) : q_size;
        c_addr     = accept ? req_addr : q_addr;
        c_wdata    = accept ? req_wdata : q_wdata;
        commit     = (accept && WAITS == 0) || (state == WAIT && cnt == 4'd0);
        err        = c_size == SZ_RSVD || (ALIGN_EN && misalign);
        rword      = mem[c_addr[ADDR_W-1:2]];
        state_d    = state == RESP ? IDLE : commit ? RESP : accept ? WAIT : state;
    end

    dmem_lane_unit u_lane (
        .size     (c_size),
        .addr     (c_addr[1:0]),
        .wdata    (c_wdata),
        .rdata    (rword),
        .uns      (c_unsigned),
        .be       (be),
        .wword    (wword),
        .ldata    (ldata),
        .misalign (misalign)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            q_write    <= 1'b0;
            q_unsigned <= 1'b0;
            q_size     <= SZ_BYTE;
            q_addr     <= '0;
            q_wdata    <= 32'd0;
            rsp_rdata  <= 32'd0;
            rsp_err    <= 1'b0;
        end else begin
            state <= state_d;
            if (accept) begin
                q_write    <= req_write;
                q_unsigned <= req_unsigned;
                q_size     <= size_t'(req_size);
                q_addr     <= req_addr;
                q_wdata    <= req_wdata;
                cnt        <= CNT_INIT;
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (commit) begin
                rsp_err   <= err;
                rsp_rdata <= (err || c_write) ? 32'd0 : ldata;
            end
        end
    end

    // Storage is deliberately outside the reset domain so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (rst_n && commit && c_write && !err)
            for (int b = 0; b < 4; b++)
                if (be[b]) mem[c_addr[ADDR_W-1:2]][8*b +: 8] <= wword[8*b +: 8];
    end

endmodule

// File: tb/tb_data_memory_bus.sv
// tb_data_memory_bus: two instances (0 and 3 wait states) checked every cycle against a byte-array model.
module tb_data_memory_bus;

`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  rv = '0, rw = '0, run = '0;
    logic [1:0]  ready_v, valid_v, err_v;
    logic [1:0]  sz_v [2];
    logic [7:0]  a_v  [2];
    logic [31:0] wd_v [2];
    logic [31:0] rd_v [2];
    int          wt [2] = '{0, 3};
    int          cyc = 0;
    int          n_cmp = 0, n_bad = 0;

    bit [7:0]    mb [2][256];
    bit          busy [2], resp [2];
    int          rem [2];
    bit [31:0]   m_rd [2];
    bit          m_err [2];
    bit          p_wr [2], p_uns [2];
    bit [1:0]    p_sz [2];
    bit [7:0]    p_a [2];
    bit [31:0]   p_wd [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_memory_bus #(.ADDR_W(8), .WAIT_CYCLES(0)) u0 (
        .clk(clk), .rst_n(rst_n), .req_valid(rv[0]), .req_ready(ready_v[0]), .req_write(rw[0]),
        .req_size(sz_v[0]), .req_unsigned(run[0]), .req_addr(a_v[0]), .req_wdata(wd_v[0]),
        .rsp_valid(valid_v[0]), .rsp_rdata(rd_v[0]), .rsp_err(err_v[0]));

    data_memory_bus #(.ADDR_W(8), .WAIT_CYCLES(3)) u3 (
        .clk(clk), .rst_n(rst_n), .req_valid(rv[1]), .req_ready(ready_v[1]), .req_write(rw[1]),
        .req_size(sz_v[1]), .req_unsigned(run[1]), .req_addr(a_v[1]), .req_wdata(wd_v[1]),
        .rsp_valid(valid_v[1]), .rsp_rdata(rd_v[1]), .rsp_err(err_v[1]));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: memory as little-endian bytes; an access touches n bytes from the size-aligned base.
    task automatic commit(input int i);
        int n, a, base;
        bit e;
        bit [31:0] v;
        n = p_sz[i] == 2'd0 ? 1 : p_sz[i] == 2'd1 ? 2 : 4;
        a = int'(p_a[i]);
        e = p_sz[i] == 2'd3 || (ALIGN && a % n != 0);
        base = a - a % n;
        v = 0;
        m_err[i] = e;
        m_rd[i] = 0;
        if (!e)
            for (int k = 0; k < n; k++)
                if (p_wr[i]) mb[i][base + k] = p_wd[i][8*k +: 8];
                else v[8*k +: 8] = mb[i][base + k];
        if (!e && !p_wr[i])
            m_rd[i] = (n < 4 && !p_uns[i] && v[8*n-1]) ? v | (32'hFFFF_FFFF << (8*n)) : v;
        resp[i] = 1;
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        for (int i = 0; i < 2; i++)
            if (!rst_n) begin
                busy[i] = 0; resp[i] = 0; m_rd[i] = 0; m_err[i] = 0;
            end else if (resp[i]) begin
                resp[i] = 0;
            end else if (busy[i]) begin
                rem[i]--;
                if (rem[i] == 0) begin busy[i] = 0; commit(i); end
            end else if (rv[i]) begin
                p_wr[i] = rw[i]; p_sz[i] = sz_v[i]; p_uns[i] = run[i]; p_a[i] = a_v[i]; p_wd[i] = wd_v[i];
                rem[i] = wt[i];
                if (rem[i] == 0) commit(i); else busy[i] = 1;
            end
    end

    always @(negedge clk)
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("u%0d ready", i), 32'(ready_v[i]), 32'(!(busy[i] || resp[i])));
            chk($sformatf("u%0d valid", i), 32'(valid_v[i]), 32'(resp[i]));
            chk($sformatf("u%0d rdata", i), rd_v[i], m_rd[i]);
            chk($sformatf("u%0d err", i), 32'(err_v[i]), 32'(m_err[i]));
        end

    task automatic wait_ready(input int i);
        int t = 0;
        while (!ready_v[i] && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) chk("ready timeout", 32'(ready_v[i]), 32'd1);
    endtask

    task automatic txn(input int i, input bit wr, input logic [1:0] sz, input bit uns, input logic [7:0] a,
                       input logic [31:0] wd, output logic [31:0] rd, output logic er, output int lat);
        int t = 0, acc;
        wait_ready(i);
        rv[i] = 1; rw[i] = wr; sz_v[i] = sz; run[i] = uns; a_v[i] = a; wd_v[i] = wd;
        acc = cyc;
        @(negedge clk);
        rv[i] = 0; rw[i] = 1'($urandom); sz_v[i] = 2'($urandom); a_v[i] = 8'($urandom); wd_v[i] = $urandom;
        while (!valid_v[i] && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) chk("rsp timeout", 32'(valid_v[i]), 32'd1);
        rd = rd_v[i];
        er = err_v[i];
        lat = cyc - acc;
    endtask

    initial begin
        logic [31:0] rd;
        logic er;
        int lat;
        int accs [$];
        for (int i = 0; i < 2; i++) begin sz_v[i] = 0; a_v[i] = 0; wd_v[i] = 0; end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("reset ready", 32'(ready_v[i]), 32'd1);
            chk("reset valid", 32'(valid_v[i]), 32'd0);
            chk("reset rdata", rd_v[i], 32'd0);
            chk("reset err", 32'(err_v[i]), 32'd0);
        end
        #2 rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 64; k++) txn(i, 1, 2'd2, 0, 8'(k * 4), 32'd0, rd, er, lat);

        txn(0, 1, 2'd2, 0, 8'h08, 32'hDEADBEEF, rd, er, lat);
        chk("u0 store latency", 32'(lat), 32'd1);
        txn(0, 0, 2'd2, 0, 8'h08, 32'd0, rd, er, lat);
        chk("ld word 08", rd, 32'hDEADBEEF);
        chk("ld word 08 err", 32'(er), 32'd0);
        chk("u0 load latency", 32'(lat), 32'd1);

        txn(0, 1, 2'd2, 0, 8'h0C, 32'h11223344, rd, er, lat);
        txn(0, 1, 2'd0, 0, 8'h0D, 32'h00000080, rd, er, lat);
        txn(0, 0, 2'd2, 0, 8'h0C, 32'd0, rd, er, lat);
        chk("word 0C after byte", rd, 32'h11228044);
        txn(0, 0, 2'd0, 0, 8'h0D, 32'd0, rd, er, lat);
        chk("ld byte signed 0D", rd, 32'hFFFFFF80);
        txn(0, 0, 2'd0, 1, 8'h0D, 32'd0, rd, er, lat);
        chk("ld byte unsigned 0D", rd, 32'h00000080);

        txn(0, 1, 2'd2, 0, 8'h10, 32'h76541234, rd, er, lat);
        txn(0, 1, 2'd1, 0, 8'h12, 32'h0000BEEF, rd, er, lat);
        txn(0, 0, 2'd1, 0, 8'h12, 32'd0, rd, er, lat);
        chk("ld half signed 12", rd, 32'hFFFFBEEF);
        txn(0, 0, 2'd2, 0, 8'h10, 32'd0, rd, er, lat);
        chk("word 10 after half", rd, 32'hBEEF1234);

        txn(0, 1, 2'd2, 0, 8'h05, 32'h99887766, rd, er, lat);
        chk("misaligned word err", 32'(er), 32'(ALIGN));
        chk("misaligned word rdata", rd, 32'd0);
        txn(0, 0, 2'd2, 0, 8'h04, 32'd0, rd, er, lat);
        chk("word 04 after misaligned", rd, ALIGN ? 32'd0 : 32'h99887766);
        txn(0, 0, 2'd3, 0, 8'h08, 32'd0, rd, er, lat);
        chk("size 11 err", 32'(er), 32'd1);
        chk("size 11 rdata", rd, 32'd0);

        txn(1, 0, 2'd2, 0, 8'h08, 32'd0, rd, er, lat);
        chk("u3 latency", 32'(lat), 32'd4);

        wait_ready(1);
        rv[1] = 1; rw[1] = 0; sz_v[1] = 2'd2; a_v[1] = 8'h08;
        for (int k = 0; k < 15; k++) begin
            if (ready_v[1]) accs.push_back(cyc);
            @(negedge clk);
        end
        rv[1] = 0;
        chk("held valid accepts", 32'(accs.size()), 32'd3);
        if (accs.size() >= 2) chk("held valid spacing", 32'(accs[1] - accs[0]), 32'd5);

        txn(1, 1, 2'd2, 0, 8'h20, 32'h12345678, rd, er, lat);
        txn(1, 0, 2'd2, 0, 8'h20, 32'd0, rd, er, lat);
        chk("u3 ld 20 before abort", rd, 32'h12345678);
        wait_ready(1);
        rv[1] = 1; rw[1] = 1; sz_v[1] = 2'd2; a_v[1] = 8'h20; wd_v[1] = 32'h5555AAAA;
        @(negedge clk);
        rv[1] = 0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("abort ready", 32'(ready_v[1]), 32'd1);
        chk("abort valid", 32'(valid_v[1]), 32'd0);
        chk("abort rdata", rd_v[1], 32'd0);
        chk("abort err", 32'(err_v[1]), 32'd0);
        #2 rst_n = 1'b1;
        repeat (6) @(negedge clk);
        txn(1, 0, 2'd2, 0, 8'h20, 32'd0, rd, er, lat);
        chk("u3 ld 20 after abort", rd, 32'h12345678);

        repeat (400) begin
            txn($urandom_range(1, 0), 1'($urandom), 2'($urandom_range(3, 0)), 1'($urandom),
                8'($urandom), $urandom, rd, er, lat);
            repeat ($urandom_range(2, 0)) @(negedge clk);
        end
        repeat (8) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
